// File: rtl/gb_cpu_common_pkg.sv
// Shared types and constants for the gb_cpu front end.
package gb_cpu_common_pkg;

  localparam int unsigned BYTE_W = 8;

  // Instruction-register control states
  typedef enum logic [1:0] {
    IR_RUN    = 2'd0,
    IR_PREFIX = 2'd1,
    IR_HALT   = 2'd2
  } ir_state_t;

  localparam logic [BYTE_W-1:0] OPC_NOP       = 8'h00;
  localparam logic [BYTE_W-1:0] OPC_HALT      = 8'h76;
  localparam logic [BYTE_W-1:0] OPC_PREFIX_CB = 8'hCB;

endpackage

// File: rtl/gb_cpu_ir_control.sv
// Instruction register and fetch control, upstream of gb_cpu_decoder.
// Captures opcode bytes on fetch M-cycles, tracks the CB prefix, handles
// HALT entry/exit, the HALT bug and the interrupt-dispatch decision.
// Ports:
//   clk, reset     : core clock (one edge per M-cycle), sync active-high reset
//   mem_rdata      : data-bus byte read this M-cycle
//   fetch_en       : this M-cycle is the opcode fetch
//   halt_req       : current instruction is HALT (qualifies fetch_en)
//   ime            : interrupt master enable
//   int_pending    : (IE & IF) != 0
//   opcode         : instruction register to decoder
//   cb_prefix      : opcode is from the CB table
//   pc_inc         : combinational, increment PC this M-cycle
//   int_dispatch   : next instruction is the interrupt-dispatch sequence
//   halted         : CPU is in HALT
module gb_cpu_ir_control
  import gb_cpu_common_pkg::*;
#(
  parameter logic [BYTE_W-1:0] RESET_OPCODE  = OPC_NOP,
  parameter logic [BYTE_W-1:0] PREFIX_OPCODE = OPC_PREFIX_CB
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] mem_rdata,
  input  logic              fetch_en,
  input  logic              halt_req,
  input  logic              ime,
  input  logic              int_pending,
  output logic [BYTE_W-1:0] opcode,
  output logic              cb_prefix,
  output logic              pc_inc,
  output logic              int_dispatch,
  output logic              halted
);

  ir_state_t         state, state_n;
  logic [BYTE_W-1:0] opcode_n;
  logic              cb_prefix_n;
  logic              int_dispatch_n;
  logic              halted_n;
  logic              halt_bug_c;
  logic              pc_inc_c;

  // HALT with a pending interrupt but IME clear: the next byte is fetched twice
  assign halt_bug_c = halt_req & int_pending & ~ime;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IR_RUN;
      opcode       <= RESET_OPCODE;
      cb_prefix    <= 1'b0;
      int_dispatch <= 1'b0;
      halted       <= 1'b0;
    end else begin
      state        <= state_n;
      opcode       <= opcode_n;
      cb_prefix    <= cb_prefix_n;
      int_dispatch <= int_dispatch_n;
      halted       <= halted_n;
    end
  end

  // Next-state and pc increment decision
  always_comb begin
    state_n        = state;
    opcode_n       = opcode;
    cb_prefix_n    = cb_prefix;
    int_dispatch_n = int_dispatch;
    halted_n       = halted;
    pc_inc_c       = 1'b0;

    case (state)
      IR_RUN: begin
        if (fetch_en) begin
          if (halt_req && !int_pending) begin
            state_n  = IR_HALT;
            halted_n = 1'b1;
          end else if (int_pending && ime) begin
            // Dispatch replaces the fetched byte; PC must not move
            int_dispatch_n = 1'b1;
          end else begin
            opcode_n       = mem_rdata;
            cb_prefix_n    = 1'b0;
            int_dispatch_n = 1'b0;
            pc_inc_c       = ~halt_bug_c;
            if (!halt_bug_c && (mem_rdata == PREFIX_OPCODE)) begin
              state_n = IR_PREFIX;
            end
          end
        end
      end

      IR_PREFIX: begin
        // Prefix pair is atomic: no interrupt or halt check here
        if (fetch_en) begin
          opcode_n    = mem_rdata;
          cb_prefix_n = 1'b1;
          pc_inc_c    = 1'b1;
          state_n     = IR_RUN;
        end
      end

      IR_HALT: begin
        if (int_pending) begin
          halted_n       = 1'b0;
          int_dispatch_n = ime;
          state_n        = IR_RUN;
        end
      end

      default: begin
        state_n = IR_RUN;
      end
    endcase
  end

  assign pc_inc = pc_inc_c & ~reset;

endmodule

// File: tb/tb_gb_cpu_ir_control.sv
// Self-checking bench for gb_cpu_ir_control: directed vectors, a behavioural
// model checked every cycle, plus literal expectations at key points.
module tb_gb_cpu_ir_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] mem_rdata;
  logic       fetch_en;
  logic       halt_req;
  logic       ime;
  logic       int_pending;
  logic [7:0] opcode;
  logic       cb_prefix;
  logic       pc_inc;
  logic       int_dispatch;
  logic       halted;

  int checks = 0;
  int errors = 0;

  // Model of the architectural view
  logic [7:0] m_opcode;
  logic       m_cb;
  logic       m_disp;
  logic       m_halted;
  logic       m_cb_next;     // last byte was an unconsumed 0xCB prefix
  logic       last_pc_inc;   // pc_inc sampled during the most recent step

  gb_cpu_ir_control dut (
    .clk          (clk),
    .reset        (reset),
    .mem_rdata    (mem_rdata),
    .fetch_en     (fetch_en),
    .halt_req     (halt_req),
    .ime          (ime),
    .int_pending  (int_pending),
    .opcode       (opcode),
    .cb_prefix    (cb_prefix),
    .pc_inc       (pc_inc),
    .int_dispatch (int_dispatch),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // What the PC should do this M-cycle, from the architectural rules
  function automatic logic model_pc_inc();
    if (reset || m_halted || !fetch_en) return 1'b0;
    if (m_cb_next) return 1'b1;
    if (halt_req) return 1'b0;          // enters HALT, dispatches, or HALT bug
    if (ime && int_pending) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_opcode = 8'h00; m_cb = 1'b0; m_disp = 1'b0; m_halted = 1'b0; m_cb_next = 1'b0;
    end else if (m_halted) begin
      if (int_pending) begin
        m_halted = 1'b0;
        m_disp   = ime;
      end
    end else if (fetch_en) begin
      if (m_cb_next) begin
        m_opcode = mem_rdata; m_cb = 1'b1; m_cb_next = 1'b0;
      end else if (halt_req && !int_pending) begin
        m_halted = 1'b1;
      end else if (ime && int_pending) begin
        m_disp = 1'b1;
      end else begin
        m_opcode  = mem_rdata; m_cb = 1'b0; m_disp = 1'b0;
        m_cb_next = (mem_rdata == 8'hCB) && !halt_req;
      end
    end
  endtask

  // One M-cycle: drive, check pc_inc mid-cycle, clock, check registers
  task automatic step(input logic rst, input logic fe, input logic hr,
                      input logic ie, input logic ip, input logic [7:0] rd);
    @(negedge clk);
    reset = rst; fetch_en = fe; halt_req = hr; ime = ie; int_pending = ip; mem_rdata = rd;
    #1;
    last_pc_inc = pc_inc;
    chk("pc_inc", {7'd0, pc_inc}, {7'd0, model_pc_inc()});
    @(posedge clk);
    model_edge();
    #1;
    chk("opcode", opcode, m_opcode);
    chk("cb_prefix", {7'd0, cb_prefix}, {7'd0, m_cb});
    chk("int_dispatch", {7'd0, int_dispatch}, {7'd0, m_disp});
    chk("halted", {7'd0, halted}, {7'd0, m_halted});
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; halt_req = 1'b0; ime = 1'b0; int_pending = 1'b0;
    mem_rdata = 8'h00;
    m_opcode = 8'h00; m_cb = 1'b0; m_disp = 1'b0; m_halted = 1'b0; m_cb_next = 1'b0;
    last_pc_inc = 1'b0;

    // Reset, with fetch_en high to show pc_inc is gated
    step(1, 1, 0, 0, 0, 8'hAB);
    step(1, 1, 0, 1, 1, 8'hAB);
    chk("lit_rst_opcode", opcode, 8'h00);
    chk("lit_rst_pc_inc", {7'd0, last_pc_inc}, 8'h00);

    // Plain fetch
    step(0, 1, 0, 0, 0, 8'hAB);
    chk("lit_fetch_ab", opcode, 8'hAB);
    chk("lit_fetch_ab_pc", {7'd0, last_pc_inc}, 8'h01);

    // CB prefix pair, then a normal fetch clears cb_prefix
    step(0, 1, 0, 0, 0, 8'hCB);
    chk("lit_cb_first", {opcode[7:1], cb_prefix}, {7'h65, 1'b0});
    step(0, 0, 0, 0, 0, 8'hFF);           // idle cycle inside PREFIX
    step(0, 1, 1, 0, 0, 8'h37);           // halt_req ignored in PREFIX
    chk("lit_cb_37", opcode, 8'h37);
    chk("lit_cb_37_flag", {7'd0, cb_prefix}, 8'h01);
    step(0, 1, 0, 0, 0, 8'h00);
    chk("lit_cb_clear", {7'd0, cb_prefix}, 8'h00);

    // Interrupt during prefix second byte is deferred to the next boundary
    step(0, 1, 0, 0, 0, 8'hCB);
    step(0, 1, 0, 1, 1, 8'h11);
    chk("lit_prefix_int_op", opcode, 8'h11);
    chk("lit_prefix_int_disp", {7'd0, int_dispatch}, 8'h00);
    step(0, 1, 0, 1, 1, 8'h22);
    chk("lit_dispatch", {7'd0, int_dispatch}, 8'h01);
    chk("lit_dispatch_pc", {7'd0, last_pc_inc}, 8'h00);
    chk("lit_dispatch_op", opcode, 8'h11);
    step(0, 0, 0, 0, 0, 8'h00);           // dispatch held while idle
    step(0, 1, 0, 0, 0, 8'h22);
    chk("lit_after_disp", opcode, 8'h22);

    // HALT entry, idle in HALT with fetch_en toggling, wake with ime=0
    step(0, 1, 1, 0, 0, 8'h76);
    for (int i = 0; i < 5; i++) step(0, 1'(i % 2), 0, 0, 0, 8'h99);
    chk("lit_halted", {7'd0, halted}, 8'h01);
    chk("lit_halt_op", opcode, 8'h22);
    step(0, 0, 0, 0, 1, 8'h00);
    chk("lit_wake_noime", {6'd0, halted, int_dispatch}, 8'h00);
    step(0, 1, 0, 0, 0, 8'h3C);
    chk("lit_wake_fetch", opcode, 8'h3C);
    chk("lit_wake_fetch_pc", {7'd0, last_pc_inc}, 8'h01);

    // HALT bug: byte latched, PC not advanced, then re-fetched
    step(0, 1, 1, 0, 1, 8'h04);
    chk("lit_hbug_op", opcode, 8'h04);
    chk("lit_hbug_pc", {7'd0, last_pc_inc}, 8'h00);
    chk("lit_hbug_halted", {7'd0, halted}, 8'h00);
    step(0, 1, 0, 0, 0, 8'h04);
    chk("lit_hbug_refetch_pc", {7'd0, last_pc_inc}, 8'h01);

    // HALT bug on a 0xCB byte does not enter PREFIX
    step(0, 1, 1, 0, 1, 8'hCB);
    step(0, 1, 0, 0, 0, 8'h05);
    chk("lit_hbug_cb", {7'd0, cb_prefix}, 8'h00);

    // HALT + pending interrupt with ime=1 dispatches directly
    step(0, 1, 1, 1, 1, 8'h76);
    chk("lit_halt_ime_disp", {6'd0, halted, int_dispatch}, 8'h01);
    step(0, 1, 0, 0, 0, 8'h07);

    // HALT then wake with ime=1
    step(0, 1, 1, 0, 0, 8'h76);
    step(0, 0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 1, 1, 8'h00);
    chk("lit_wake_ime", {6'd0, halted, int_dispatch}, 8'h01);

    // Double 0xCB is a CB opcode, not a new prefix
    step(0, 1, 0, 0, 0, 8'h08);
    step(0, 1, 0, 0, 0, 8'hCB);
    step(0, 1, 0, 0, 0, 8'hCB);
    chk("lit_cbcb", {opcode[7:1], cb_prefix}, {7'h65, 1'b1});
    step(0, 1, 0, 0, 0, 8'h01);
    chk("lit_cbcb_next", {7'd0, cb_prefix}, 8'h00);

    // Reset while in HALT
    step(0, 1, 1, 0, 0, 8'h76);
    step(1, 0, 0, 0, 0, 8'h00);
    chk("lit_rst_halt", {opcode[7:2], halted, int_dispatch}, 8'h00);

    // Reset while in PREFIX; next byte must not be treated as CB opcode
    step(0, 1, 0, 0, 0, 8'hCB);
    step(1, 1, 0, 0, 0, 8'h12);
    chk("lit_rst_prefix", {opcode[7:1], cb_prefix}, 8'h00);
    step(0, 1, 0, 0, 0, 8'h12);
    chk("lit_rst_prefix_next", {7'd0, cb_prefix}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
